rs_alu_sched: RTL and testbench

- Issue scheduler between the ALU reservation station (RS) and the single-cycle ALU.
- Each cycle, picks one ready RS entry by round-robin and sequences it through a 2-stage ALU pipeline: issue stage, then result stage.
- Holds the result stage until the common data bus (CDB) arbiter grants it, and stalls the pipeline meanwhile.
- Supports a synchronous flush on branch mispredict.

---
 rtl/rs_alu_sched_pkg.sv | 12 +
 rtl/rs_alu_sched_rr_pick.sv | 39 +++
 rtl/rs_alu_sched.sv | 71 +++++++
 tb/tb_rs_alu_sched.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/rs_alu_sched_pkg.sv
// Shared constants for the ALU reservation-station datapath and its issue scheduler.
package rs_alu_sched_pkg;

    localparam int RS_SIZE_DEFAULT = 16;
    localparam int ROB_TAG_W       = 5;

    // Round-robin successor of entry k in a ring of n entries (n need not be a power of two).
    function automatic int wrap_next(input int k, input int n);
        return (k + 1 == n) ? 0 : k + 1;
    endfunction

endpackage

// File: rtl/rs_alu_sched_rr_pick.sv
// Rotating priority encoder: first requester at or after ptr, wrapping past N-1 back to 0.
module rs_alu_sched_rr_pick #(
    parameter  int N  = 16,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          found
);

    int            cand;
    logic [IW-1:0] sel;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        sel   = '0;
        if (en) begin
            for (int i = 0; i < N; i++) begin
                cand = int'(ptr) + i;
                if (cand >= N) begin
                    cand = cand - N;
                end
                sel = IW'(cand);
                if (!found && req[sel]) begin
                    found      = 1'b1;
                    idx        = sel;
                    grant[sel] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rs_alu_sched.sv
// ALU issue scheduler: round-robin pick from the RS, then issue and result stages,
// with the result stage held until the CDB arbiter accepts it.
module rs_alu_sched
    import rs_alu_sched_pkg::*;
#(
    parameter  int RS_SIZE = RS_SIZE_DEFAULT,
    localparam int IDX_W   = $clog2(RS_SIZE)
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic               clear_in,
    input  logic [RS_SIZE-1:0] req_in,
    output logic [RS_SIZE-1:0] grant_out,
    output logic               issue_valid_out,
    output logic [IDX_W-1:0]   issue_idx_out,
    output logic               alu_stall_out,
    output logic               cdb_req_out,
    input  logic               cdb_grant_in,
    output logic               busy_out
);

    logic             s1;
    logic             s2;
    logic             advance;
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] rr_ptr;

    // Gating on rst_in keeps the RS from freeing entries while the pipeline is held in reset.
    assign advance       = rst_in & rdy_in & ~clear_in & (~s2 | cdb_grant_in);
    assign alu_stall_out = s2 & ~cdb_grant_in & rdy_in;

    assign issue_valid_out = s1;
    assign cdb_req_out     = s2;
    assign busy_out        = s1 | s2;

    rs_alu_sched_rr_pick #(
        .N (RS_SIZE)
    ) u_pick (
        .req   (req_in),
        .ptr   (rr_ptr),
        .en    (advance),
        .grant (grant_out),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rr_ptr        <= '0;
            s1            <= 1'b0;
            s2            <= 1'b0;
            issue_idx_out <= '0;
        end else if (rdy_in) begin
            if (clear_in) begin
                // Flush wins over a same-cycle CDB grant; that result is dropped.
                s1 <= 1'b0;
                s2 <= 1'b0;
            end else if (advance) begin
                s2 <= s1;
                s1 <= pick_found;
                if (pick_found) begin
                    issue_idx_out <= pick_idx;
                    rr_ptr        <= IDX_W'(wrap_next(int'(pick_idx), RS_SIZE));
                end
            end
        end
    end

endmodule

// File: tb/tb_rs_alu_sched.sv
// Directed bench for rs_alu_sched: a spec-level model checked every cycle plus literal spot checks.
module tb_rs_alu_sched;

    localparam int RS = 16;
    localparam int IW = $clog2(RS);

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          rdy_in;
    logic          clear_in;
    logic [RS-1:0] req_in;
    logic [RS-1:0] grant_out;
    logic          issue_valid_out;
    logic [IW-1:0] issue_idx_out;
    logic          alu_stall_out;
    logic          cdb_req_out;
    logic          cdb_grant_in;
    logic          busy_out;

    int checks_total  = 0;
    int checks_passed = 0;

    // Abstract model: round-robin pointer, two pipeline slots, last issued index.
    int m_rr  = 0;
    bit m_s1  = 0;
    bit m_s2  = 0;
    int m_idx = 0;

    rs_alu_sched #(.RS_SIZE(RS)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .rdy_in          (rdy_in),
        .clear_in        (clear_in),
        .req_in          (req_in),
        .grant_out       (grant_out),
        .issue_valid_out (issue_valid_out),
        .issue_idx_out   (issue_idx_out),
        .alu_stall_out   (alu_stall_out),
        .cdb_req_out     (cdb_req_out),
        .cdb_grant_in    (cdb_grant_in),
        .busy_out        (busy_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_total++;
        if (act !== exp) begin
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end else begin
            checks_passed++;
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic [RS-1:0] req, input logic cg,
                                 input logic clr, input logic rdy);
        @(posedge clk_in);
        #1;
        rst_in       = rst;
        req_in       = req;
        cdb_grant_in = cg;
        clear_in     = clr;
        rdy_in       = rdy;
        #1;
    endtask

    // Index the scheduler must grant this cycle, or -1 for none.
    function automatic int modelPick();
        if (!rst_in || !rdy_in || clear_in || (m_s2 && !cdb_grant_in)) return -1;
        for (int i = 0; i < RS; i++) begin
            if (req_in[(m_rr + i) % RS]) return (m_rr + i) % RS;
        end
        return -1;
    endfunction

    function automatic logic [RS-1:0] modelGrant();
        int k;
        k = modelPick();
        if (k < 0) return '0;
        return RS'(1) << k;
    endfunction

    initial begin
        forever begin
            @(posedge clk_in or negedge rst_in);
            if (!rst_in) begin
                m_rr = 0; m_s1 = 0; m_s2 = 0; m_idx = 0;
            end else if (rdy_in) begin
                if (clear_in) begin
                    m_s1 = 0; m_s2 = 0;
                end else if (!m_s2 || cdb_grant_in) begin
                    int k;
                    k    = modelPick();
                    m_s2 = m_s1;
                    m_s1 = (k >= 0);
                    if (k >= 0) begin
                        m_idx = k;
                        m_rr  = (k + 1) % RS;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk_in);
            checkOutput("m_grant", 32'(grant_out), 32'(modelGrant()));
            checkOutput("m_issue_valid", 32'(issue_valid_out), 32'(m_s1));
            checkOutput("m_issue_idx", 32'(issue_idx_out), 32'(m_idx));
            checkOutput("m_cdb_req", 32'(cdb_req_out), 32'(m_s2));
            checkOutput("m_stall", 32'(alu_stall_out), 32'(m_s2 && !cdb_grant_in && rdy_in));
            checkOutput("m_busy", 32'(busy_out), 32'(m_s1 || m_s2));
        end
    end

    initial begin
        rst_in = 1'b0; req_in = 16'hFFFF; rdy_in = 1'b1; clear_in = 1'b0; cdb_grant_in = 1'b0;

        // Reset and idle.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_in);
            #2;
            checkOutput("rst_grant", 32'(grant_out), 32'h0);
            checkOutput("rst_busy", 32'(busy_out), 32'h0);
        end
        applyStimulus(1, 16'hFFFF, 0, 0, 1);
        checkOutput("first_grant", 32'(grant_out), 32'h0001);
        applyStimulus(1, 16'hFFFF, 1, 0, 1);
        checkOutput("second_grant", 32'(grant_out), 32'h0002);
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        #1;
        checkOutput("midrst_valid", 32'(issue_valid_out), 32'h0);
        checkOutput("midrst_cdb", 32'(cdb_req_out), 32'h0);
        checkOutput("midrst_grant", 32'(grant_out), 32'h0);
        applyStimulus(0, 16'h0000, 0, 0, 1);

        // Round-robin fairness.
        applyStimulus(1, 16'h8011, 1, 0, 1);
        checkOutput("rr_g0", 32'(grant_out), 32'h0001);
        applyStimulus(1, 16'h8011, 1, 0, 1);
        checkOutput("rr_g4", 32'(grant_out), 32'h0010);
        checkOutput("rr_idx0", 32'(issue_idx_out), 32'd0);
        checkOutput("rr_cdb_off", 32'(cdb_req_out), 32'h0);
        applyStimulus(1, 16'h8011, 1, 0, 1);
        checkOutput("rr_g15", 32'(grant_out), 32'h8000);
        checkOutput("rr_idx4", 32'(issue_idx_out), 32'd4);
        checkOutput("rr_cdb_on", 32'(cdb_req_out), 32'h1);
        applyStimulus(1, 16'h8011, 1, 0, 1);
        checkOutput("rr_g0b", 32'(grant_out), 32'h0001);
        applyStimulus(1, 16'h8011, 1, 0, 1);
        checkOutput("rr_g4b", 32'(grant_out), 32'h0010);
        for (int i = 0; i < 3; i++) applyStimulus(1, 16'h0000, 1, 0, 1);

        // CDB backpressure with op 5 in the result stage and op 6 behind it.
        applyStimulus(1, 16'h0020, 0, 0, 1);
        checkOutput("bp_g5", 32'(grant_out), 32'h0020);
        applyStimulus(1, 16'h0040, 0, 0, 1);
        checkOutput("bp_g6", 32'(grant_out), 32'h0040);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 16'h0080, 0, 0, 1);
            checkOutput("bp_nogrant", 32'(grant_out), 32'h0);
            checkOutput("bp_stall", 32'(alu_stall_out), 32'h1);
            checkOutput("bp_cdb", 32'(cdb_req_out), 32'h1);
            checkOutput("bp_idx6", 32'(issue_idx_out), 32'd6);
        end
        applyStimulus(1, 16'h0000, 1, 0, 1);
        checkOutput("bp_release", 32'(alu_stall_out), 32'h0);
        applyStimulus(1, 16'h0000, 1, 0, 1);
        checkOutput("bp_op6_cdb", 32'(cdb_req_out), 32'h1);
        checkOutput("bp_s1_empty", 32'(issue_valid_out), 32'h0);
        applyStimulus(1, 16'h0000, 0, 0, 1);
        checkOutput("bp_drained", 32'(cdb_req_out), 32'h0);

        // Wrap-around through entry 15.
        applyStimulus(1, 16'h4000, 1, 0, 1);
        checkOutput("wr_g14", 32'(grant_out), 32'h4000);
        applyStimulus(1, 16'h8001, 1, 0, 1);
        checkOutput("wr_g15", 32'(grant_out), 32'h8000);
        applyStimulus(1, 16'h8001, 1, 0, 1);
        checkOutput("wr_g0", 32'(grant_out), 32'h0001);
        applyStimulus(1, 16'h8001, 1, 0, 1);
        checkOutput("wr_ptr1", 32'(grant_out), 32'h8000);

        // Flush with both stages full and a concurrent CDB grant.
        applyStimulus(1, 16'hFFFF, 1, 1, 1);
        checkOutput("fl_nogrant", 32'(grant_out), 32'h0);
        checkOutput("fl_busy", 32'(busy_out), 32'h1);
        applyStimulus(1, 16'hFFFF, 0, 0, 1);
        checkOutput("fl_valid", 32'(issue_valid_out), 32'h0);
        checkOutput("fl_cdb", 32'(cdb_req_out), 32'h0);
        checkOutput("fl_idx_hold", 32'(issue_idx_out), 32'd15);
        checkOutput("fl_ptr_hold", 32'(grant_out), 32'h0001);

        // rdy_in low freezes everything, including a pending flush.
        applyStimulus(1, 16'h0002, 1, 0, 1);
        checkOutput("rdy_fill", 32'(grant_out), 32'h0002);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 16'hFFFF, 0, 1, 0);
            checkOutput("rdy_nogrant", 32'(grant_out), 32'h0);
            checkOutput("rdy_nostall", 32'(alu_stall_out), 32'h0);
            checkOutput("rdy_s1", 32'(issue_valid_out), 32'h1);
            checkOutput("rdy_s2", 32'(cdb_req_out), 32'h1);
            checkOutput("rdy_idx", 32'(issue_idx_out), 32'd1);
        end
        applyStimulus(1, 16'hFFFF, 0, 1, 1);
        checkOutput("rdy_fl_nogrant", 32'(grant_out), 32'h0);
        applyStimulus(1, 16'h0000, 0, 0, 1);
        checkOutput("rdy_fl_valid", 32'(issue_valid_out), 32'h0);
        checkOutput("rdy_fl_cdb", 32'(cdb_req_out), 32'h0);
        applyStimulus(1, 16'hFFFF, 0, 0, 1);
        checkOutput("rdy_ptr2", 32'(grant_out), 32'h0004);
        for (int i = 0; i < 3; i++) applyStimulus(1, 16'h0000, 1, 0, 1);

        @(posedge clk_in);
        #1;
        $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
